// File: rtl/ddram_bram_responder.sv
// ddram_bram_responder: block-RAM backed responder for the 64-bit DDRAM_* burst
// interface. It serves single and burst reads and writes with byte enables, and
// adds programmable read latency, inter-beat gaps and periodic refresh stalls so
// clients experience realistic back-pressure.
module ddram_bram_responder #(
  parameter int unsigned AW             = 12,
  parameter logic [3:0]  BASE           = 4'b0011,
  parameter int unsigned RD_LAT         = 2,
  parameter int unsigned BEAT_GAP       = 0,
  parameter int unsigned REFRESH_PERIOD = 0,
  parameter int unsigned REFRESH_LEN    = 4
) (
  input  logic        DDRAM_CLK,
  input  logic        reset,
  output logic        DDRAM_BUSY,
  input  logic [7:0]  DDRAM_BURSTCNT,
  input  logic [28:0] DDRAM_ADDR,
  input  logic        DDRAM_RD,
  input  logic        DDRAM_WE,
  input  logic [63:0] DDRAM_DIN,
  input  logic [7:0]  DDRAM_BE,
  output logic [63:0] DDRAM_DOUT,
  output logic        DDRAM_DOUT_READY,
  output logic        oob_err
);

  localparam int unsigned RCW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BEAT,
    WR_BURST,
    REFRESH
  } state_t;

  state_t         state;
  logic [AW-1:0]  idx;          // word index of the next beat
  logic [7:0]     beats_left;   // beats still to transfer in this burst
  logic           in_win;       // burst address lies inside the BASE window
  logic [3:0]     lat_cnt;
  logic [2:0]     gap_cnt;
  logic [3:0]     ref_len_cnt;
  logic [RCW-1:0] ref_cnt;
  logic           ref_pend;
  logic           ref_due;

  logic [63:0]    mem [2**AW];
  logic [63:0]    ram_q;

  logic           accept;
  logic           cmd_win;
  logic [AW-1:0]  cmd_idx;
  logic [7:0]     cmd_len;
  logic           beat_now;
  logic           wr_en;
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  rd_idx;
  logic           unused_addr;

  // Command decode for the current cycle.
  always_comb begin
    accept      = (state == IDLE) && !DDRAM_BUSY && (DDRAM_RD || DDRAM_WE);
    cmd_win     = (DDRAM_ADDR[28:25] == BASE);
    cmd_idx     = DDRAM_ADDR[AW-1:0];
    cmd_len     = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
    beat_now    = (state == RD_BEAT) && (gap_cnt == 3'd0);
    unused_addr = ^DDRAM_ADDR[24:AW];
  end

  // RAM port addressing. The read address runs one step ahead of idx so that the
  // registered RAM output always holds mem[idx] when a beat is emitted.
  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it holding its old value and no latch is inferred.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = idx;
    rd_idx = idx;
    if (accept) begin
      wr_idx = cmd_idx;
      rd_idx = cmd_idx;
      wr_en  = DDRAM_WE && cmd_win;
    end else if (state == WR_BURST) begin
      wr_en  = DDRAM_WE && in_win;
    end else if (beat_now) begin
      rd_idx = idx + AW'(1);
    end
  end

  // Single-port block RAM with byte write enables and a registered read port.
  // NOTE: the memory array has no reset; clearing it would prevent block-RAM
  // mapping, and its contents are intentionally preserved across reset.
  always_ff @(posedge DDRAM_CLK) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (DDRAM_BE[b]) mem[wr_idx][8*b +: 8] <= DDRAM_DIN[8*b +: 8];
      end
    end
    ram_q <= mem[rd_idx];
  end

  // A refresh period expires when the free-running counter reaches PERIOD-1.
  always_comb begin
    ref_due = (REFRESH_PERIOD != 0) && (ref_cnt == RCW'(REFRESH_PERIOD - 1));
  end

  // Free-running refresh period counter.
  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset)        ref_cnt <= '0;
    else if (ref_due) ref_cnt <= '0;
    else              ref_cnt <= ref_cnt + RCW'(1);
  end

  // Protocol FSM with registered BUSY, read data, beat strobe and error flag.
  // NOTE: sequential state uses non-blocking assignments only; a later
  // assignment in the same block overrides an earlier default cleanly.
  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      DDRAM_BUSY       <= 1'b1;
      DDRAM_DOUT_READY <= 1'b0;
      DDRAM_DOUT       <= '0;
      oob_err          <= 1'b0;
      ref_pend         <= 1'b0;
      idx              <= '0;
      beats_left       <= '0;
      in_win           <= 1'b0;
      lat_cnt          <= '0;
      gap_cnt          <= '0;
      ref_len_cnt      <= '0;
    end else begin
      DDRAM_DOUT_READY <= 1'b0;
      if (ref_due) ref_pend <= 1'b1;

      case (state)
        IDLE: begin
          DDRAM_BUSY <= 1'b0;
          if (accept) begin
            idx        <= cmd_idx;
            in_win     <= cmd_win;
            beats_left <= cmd_len;
            if (!cmd_win || (DDRAM_BURSTCNT == 8'd0) || (DDRAM_RD && DDRAM_WE))
              oob_err <= 1'b1;
            if (DDRAM_WE) begin
              // First write beat lands in the acceptance cycle.
              idx        <= cmd_idx + AW'(1);
              beats_left <= cmd_len - 8'd1;
              if (cmd_len > 8'd1) state <= WR_BURST;
            end else begin
              DDRAM_BUSY <= 1'b1;
              gap_cnt    <= '0;
              lat_cnt    <= 4'(RD_LAT - 1);
              state      <= (RD_LAT > 1) ? RD_WAIT : RD_BEAT;
            end
          end else if (ref_pend && !DDRAM_BUSY) begin
            // A period expiring on this very edge stays pending.
            ref_pend    <= ref_due;
            DDRAM_BUSY  <= 1'b1;
            ref_len_cnt <= 4'(REFRESH_LEN - 1);
            state       <= REFRESH;
          end
        end

        RD_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) state <= RD_BEAT;
        end

        RD_BEAT: begin
          if (gap_cnt != 3'd0) begin
            gap_cnt <= gap_cnt - 3'd1;
          end else begin
            DDRAM_DOUT_READY <= 1'b1;
            DDRAM_DOUT       <= in_win ? ram_q : 64'd0;
            idx              <= idx + AW'(1);
            beats_left       <= beats_left - 8'd1;
            gap_cnt          <= 3'(BEAT_GAP);
            if (beats_left == 8'd1) begin
              // BUSY stays high one more cycle; IDLE then releases it.
              state   <= IDLE;
              gap_cnt <= '0;
            end
          end
        end

        WR_BURST: begin
          if (DDRAM_RD) oob_err <= 1'b1;
          if (DDRAM_WE) begin
            idx        <= idx + AW'(1);
            beats_left <= beats_left - 8'd1;
            if (beats_left == 8'd1) state <= IDLE;
          end
        end

        REFRESH: begin
          if (ref_len_cnt == 4'd0) begin
            state      <= IDLE;
            DDRAM_BUSY <= 1'b0;
          end else begin
            ref_len_cnt <= ref_len_cnt - 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_bram_responder.sv
// tb_ddram_bram_responder: scoreboard bench. Stimulus pushes the expected read
// beats into a queue; an independent monitor pops and compares on every
// DOUT_READY strobe. Directed timing checks run alongside.
module tb_ddram_bram_responder;

  localparam int         AW     = 8;
  localparam logic [3:0] BASE   = 4'b0011;
  localparam logic [3:0] OTHER  = 4'b0010;
  localparam int         RD_LAT = 2;
  localparam int         GAP    = 1;
  localparam int         REF_P  = 32;
  localparam int         REF_L  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [7:0]  burstcnt = '0;
  logic [28:0] addr = '0;
  logic        rd = 1'b0;
  logic        we = 1'b0;
  logic [63:0] din = '0;
  logic [7:0]  be = '0;
  logic [63:0] dout;
  logic        dout_ready;
  logic        oob_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_n = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model [256];

  always #5 clk = ~clk;

  ddram_bram_responder #(
    .AW(AW), .BASE(BASE), .RD_LAT(RD_LAT), .BEAT_GAP(GAP),
    .REFRESH_PERIOD(REF_P), .REFRESH_LEN(REF_L)
  ) dut (
    .DDRAM_CLK(clk),
    .reset(rst),
    .DDRAM_BUSY(busy),
    .DDRAM_BURSTCNT(burstcnt),
    .DDRAM_ADDR(addr),
    .DDRAM_RD(rd),
    .DDRAM_WE(we),
    .DDRAM_DIN(din),
    .DDRAM_BE(be),
    .DDRAM_DOUT(dout),
    .DDRAM_DOUT_READY(dout_ready),
    .oob_err(oob_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic bound_expired(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [28:0] mk_addr(input logic [3:0] w, input int i);
    return {w, 25'(i)};
  endfunction

  function automatic logic [63:0] pat(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  task automatic model_write(input int i, input logic [63:0] d, input logic [7:0] b);
    for (int k = 0; k < 8; k++)
      if (b[k]) model[i % 256][8*k +: 8] = d[8*k +: 8];
  endtask

  // Edge counter since reset release, used to predict refresh due points.
  always @(posedge clk) begin
    if (rst) edge_n = 0;
    else     edge_n++;
  end

  // Monitor: every read beat is matched against the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (dout_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_beat: got beat with dout %h, want no beat", dout);
      end else begin
        check("read_data", dout, exp_q.pop_front());
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy === 1'b0) return;
    end
    bound_expired("wait_idle");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) return;
    end
    bound_expired("wait_drain");
  endtask

  task automatic write_cmd(input logic [3:0] w, input int i, input logic [63:0] d, input logic [7:0] b);
    wait_idle();
    addr = mk_addr(w, i); burstcnt = 8'd1; din = d; be = b; we = 1'b1;
    if (w == BASE) model_write(i, d, b);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic read_cmd(input logic [3:0] w, input int i, input int bc);
    int n;
    n = (bc == 0) ? 1 : bc;
    wait_idle();
    addr = mk_addr(w, i); burstcnt = 8'(bc); rd = 1'b1;
    for (int j = 0; j < n; j++) exp_q.push_back((w == BASE) ? model[(i + j) % 256] : 64'd0);
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rd = 1'b0; we = 1'b0;
    #1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          beats, last, first_at, gap_bad, t, n;
    logic        exp7;
    logic [5:0]  we_pat;

    // Reset state and release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_ready", dout_ready, 0);
    check("rst_dout", dout, 0);
    check("rst_oob", oob_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("release_busy", busy, 0);

    // Byte-enable merge, single-beat readback.
    write_cmd(BASE, 'h10, 64'h1122_3344_5566_7788, 8'h0F);
    write_cmd(BASE, 'h10, 64'hAAAA_AAAA_0000_0000, 8'hF0);
    wait_idle();
    addr = mk_addr(BASE, 'h10); burstcnt = 8'd1; rd = 1'b1;
    exp_q.push_back(64'hAAAA_AAAA_5566_7788);
    @(negedge clk); rd = 1'b0;
    wait_drain();

    // Two-beat read timing relative to the acceptance edge.
    write_cmd(BASE, 'h11, 64'h0123_4567_89AB_CDEF, 8'hFF);
    wait_idle();
    addr = mk_addr(BASE, 'h10); burstcnt = 8'd2; rd = 1'b1;
    exp_q.push_back(64'hAAAA_AAAA_5566_7788);
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    @(posedge clk); #1;
    rd = 1'b0;
    check("rd2_busy_t0", busy, 1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("rd2_ready_t%0d", k), dout_ready, 64'(k == 2 || k == 4));
      check($sformatf("rd2_busy_t%0d", k), busy, 64'(k <= 4));
    end
    wait_drain();

    // Gapped write burst (WE 1,0,1,1,0,1) ignoring ADDR/BURSTCNT mid-burst.
    write_cmd(BASE, 'h44, 64'h4444_4444_4444_4444, 8'hFF);
    we_pat = 6'b101101;
    n = 0;
    wait_idle();
    addr = mk_addr(BASE, 'h40); burstcnt = 8'd4; be = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      we = we_pat[i];
      if (we_pat[i]) begin
        din = 64'hB0B0_0000_0000_0000 | 64'(n);
        model_write('h40 + n, din, be);
        n++;
      end
      if (i == 1) begin
        addr = mk_addr(BASE, 'h70); burstcnt = 8'd1;
      end
      @(negedge clk);
    end
    we = 1'b0;
    write_cmd(BASE, 'h50, 64'h5050_5050_5050_5050, 8'hFF);
    wait_idle();
    addr = mk_addr(BASE, 'h40); burstcnt = 8'd5; rd = 1'b1;
    exp_q.push_back(64'hB0B0_0000_0000_0000);
    exp_q.push_back(64'hB0B0_0000_0000_0001);
    exp_q.push_back(64'hB0B0_0000_0000_0002);
    exp_q.push_back(64'hB0B0_0000_0000_0003);
    exp_q.push_back(64'h4444_4444_4444_4444);
    @(negedge clk); rd = 1'b0;
    read_cmd(BASE, 'h50, 1);
    wait_drain();
    check("oob_clean", oob_err, 0);

    // 128-beat write then gapped 128-beat read wrapping at 2^AW, then refresh.
    wait_idle();
    addr = mk_addr(BASE, 192); burstcnt = 8'd128; be = 8'hFF; we = 1'b1;
    for (int i = 0; i < 128; i++) begin
      din = pat(i);
      model_write(192 + i, din, be);
      @(negedge clk);
    end
    we = 1'b0;
    wait_idle();
    addr = mk_addr(BASE, 192); burstcnt = 8'd128; rd = 1'b1;
    for (int i = 0; i < 128; i++) exp_q.push_back(pat(i));
    @(posedge clk); #1;
    rd = 1'b0;
    t = edge_n;
    beats = 0; last = -1; first_at = -1; gap_bad = 0;
    for (int c = 0; c < 600 && beats < 128; c++) begin
      @(posedge clk); #1;
      if (dout_ready === 1'b1) begin
        if (beats == 0) first_at = edge_n - t;
        else if (edge_n - last != 2) gap_bad++;
        last = edge_n;
        beats++;
      end
    end
    if (beats < 128) bound_expired("wrap_read");
    check("wrap_beats", 64'(beats), 64'd128);
    check("wrap_first_lat", 64'(first_at), 64'd2);
    check("wrap_gap_errs", 64'(gap_bad), 64'd0);
    exp7 = 1'b0;
    for (int e = last + 2; e <= last + 6; e++) if (e % REF_P == 0) exp7 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      check($sformatf("refresh_busy_l%0d", k), busy,
            (k >= 2 && k <= 5) ? 64'd1 : ((k == 7) ? 64'(exp7) : 64'd0));
    end
    wait_drain();

    // BURSTCNT = 0 behaves as one beat and flags an error.
    read_cmd(BASE, 'h10, 0);
    wait_drain();
    repeat (4) @(posedge clk);
    check("bc0_oob", oob_err, 1);

    // Reset mid-burst abandons the burst.
    read_cmd(BASE, 'h20, 8);
    for (int i = 0; i < 100 && exp_q.size() > 6; i++) @(posedge clk);
    if (exp_q.size() > 6) bound_expired("mid_burst");
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("midrst_ready", dout_ready, 0);
    check("midrst_busy", busy, 1);
    check("midrst_oob", oob_err, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_release_busy", busy, 0);
    repeat (30) @(posedge clk);

    // RD and WE together: write wins, read dropped, error flagged.
    wait_idle();
    addr = mk_addr(BASE, 'h30); burstcnt = 8'd1; din = 64'hFEED_FACE_CAFE_BEEF; be = 8'hFF;
    rd = 1'b1; we = 1'b1;
    model_write('h30, din, be);
    @(negedge clk);
    rd = 1'b0; we = 1'b0;
    repeat (10) @(posedge clk);
    wait_idle();
    addr = mk_addr(BASE, 'h30); burstcnt = 8'd1; rd = 1'b1;
    exp_q.push_back(64'hFEED_FACE_CAFE_BEEF);
    @(negedge clk); rd = 1'b0;
    wait_drain();
    check("rdwe_oob", oob_err, 1);

    // Out-of-window accesses: writes dropped, reads return zero.
    do_reset();
    @(posedge clk); #1;
    check("reset_clears_oob", oob_err, 0);
    write_cmd(BASE, 'h20, 64'h2020_2020_2020_2020, 8'hFF);
    write_cmd(OTHER, 'h20, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF);
    wait_idle();
    check("oob_write_flag", oob_err, 1);
    read_cmd(OTHER, 'h20, 2);
    wait_drain();
    wait_idle();
    addr = mk_addr(BASE, 'h20); burstcnt = 8'd1; rd = 1'b1;
    exp_q.push_back(64'h2020_2020_2020_2020);
    @(negedge clk); rd = 1'b0;
    wait_drain();
    repeat (5) @(posedge clk);
    check("beats_outstanding", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
